int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 The parameter list SHALL be:
- VECTOR, default 32'h0000_4180, interrupt handler address (informational; PC owns the jump)
- PRID, default 32'h0000_0001, PRId read value
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk        in   1   rising-edge clock
- rst        in   1   async active-low reset
- hw_int     in   6   level hardware interrupt lines
- pc_in      in   32  PC of instruction at commit point
- pc_valid   in   1   pc_in holds a real instruction (not a bubble)
- eret       in   1   eret committing this cycle (1-cycle pulse)
- mtc0_we    in   1   CP0 write strobe
- mtc0_addr  in   5   CP0 write register number
- mtc0_data  in   32  CP0 write data
- mfc0_addr  in   5   CP0 read register number
- mfc0_data  out  32  CP0 read data (combinational)
- epc_out    out  32  current EPC, to PC block
- interupt   out  1   to PC block: load handler address next edge
- int_end    out  1   to PC block: load epc_out next edge
- flush      out  1   squash all pipeline stages younger than commit

Function
REQ-004 The block SHALL implement registers SR (#12), Cause (#13), EPC (#14) and PRId (#15, read-only, equal to PRID).
REQ-005 SR layout SHALL be IM[15:10], EXL bit 1, IE bit 0; all other bits SHALL read 0.
REQ-006 Cause.IP[15:10] SHALL be loaded from hw_int on every clock edge (1-cycle sampling latency) and SHALL ignore mtc0 writes.
REQ-007 mfc0_data SHALL return the addressed register and SHALL return 0 for unmapped addresses.
REQ-008 A request condition SHALL be defined as: |(IP & IM) & IE & ~EXL.
REQ-009 The FSM SHALL have the states IDLE, TAKE, SERVICE and RETURN.
REQ-010 IDLE: when the request condition and pc_valid are both true at an edge, the block SHALL set EPC<=pc_in and EXL<=1, then go to TAKE.
REQ-011 IDLE: while pc_valid=0, entry to TAKE SHALL be deferred and the request held pending.
REQ-012 TAKE SHALL last exactly 1 cycle, with interupt=1 and flush=1, then go to SERVICE.
REQ-013 SERVICE: an eret pulse SHALL move the FSM to RETURN; all other inputs SHALL keep it in SERVICE.
REQ-014 RETURN SHALL last exactly 1 cycle, with int_end=1 and flush=1, then go to IDLE; EXL SHALL clear on the edge leaving RETURN.
REQ-015 interupt, int_end and flush SHALL be decoded from state only (registered timing); interupt and int_end SHALL never both be 1.
REQ-016 An eret in IDLE or TAKE SHALL be ignored, with no int_end.
REQ-017 An mtc0 write to EPC on the same edge as IDLE->TAKE SHALL be dropped; the capture of pc_in wins.
REQ-018 An mtc0 write to SR on the same edge as IDLE->TAKE SHALL update IM/IE, but EXL SHALL be forced to 1.
REQ-019 An interrupt pending while in RETURN SHALL be evaluated in IDLE; the earliest re-entry to TAKE is the edge after IDLE is reached.
REQ-020 epc_out SHALL always equal the EPC register.
REQ-021 mtc0 writes to EPC in SERVICE SHALL be honoured, so the handler can adjust the return address.

Reset
REQ-022 On rst=0, asynchronously and regardless of state, the block SHALL set: SR=0, Cause=0, EPC=0, FSM=IDLE, interupt=0, int_end=0, flush=0.
REQ-023 A reset asserted during TAKE or SERVICE SHALL abort the sequence with no int_end emitted.
REQ-024 After rst deasserts, the first request SHALL be evaluatable on the first clk edge.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- SR=0x0000_0401, hw_int[0]=1, pc_valid=1, pc_in=0x3010 -> two edges later interupt=1 and flush=1 for 1 cycle, EPC=0x3010, SR.EXL=1.
- With the FSM in SERVICE, hw_int toggling -> no further interupt; then eret pulse -> next cycle int_end=1, epc_out=0x3010; SR.EXL=0 one cycle later.
- Request present with pc_valid=0 for 3 cycles -> no TAKE; on pc_valid=1 with pc_in=0x3020 -> EPC=0x3020.
- IM=0 or IE=0 with hw_int=6'h3F -> Cause.IP=0xFC00 visible via mfc0 (addr 13), interupt never asserted.
- mtc0 EPC=0x5000 on the same edge as the IDLE->TAKE transition -> EPC holds pc_in; mtc0 EPC=0x5000 in SERVICE -> return to 0x5000.
- rst=0 pulse mid-SERVICE -> all outputs 0 immediately, mfc0 of SR/EPC returns 0, FSM=IDLE.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: small CP0-style interrupt controller.
// Holds SR, Cause, EPC and PRId, decides when a hardware interrupt is taken
// at the commit point, and tells the PC block when to jump to the handler
// and when to return through EPC. The PC block owns the handler address.
module int_ctrl #(
  parameter logic [31:0] VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  output logic [31:0] epc_out,
  output logic        interupt,
  output logic        int_end,
  output logic        flush
);

  // CP0 register numbers
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // The handler address is only meaningful to the PC block, but a
  // misaligned value is always a configuration mistake.
  if (VECTOR[1:0] != 2'b00) begin : g_vector_misaligned
    $error("int_ctrl: VECTOR must be word aligned");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    TAKE    = 2'b01,
    SERVICE = 2'b10,
    RETURN  = 2'b11
  } state_t;

  // Request condition: an enabled pending line, interrupts enabled and not
  // already inside a handler.
  function automatic logic request_active(
    input logic [5:0] ip,
    input logic [5:0] im,
    input logic       ie,
    input logic       exl
  );
    return (|(ip & im)) & ie & ~exl;
  endfunction

  // Pack the architected SR fields into the 32-bit read view.
  function automatic logic [31:0] pack_sr(
    input logic [5:0] im,
    input logic       exl,
    input logic       ie
  );
    return {16'h0000, im, 8'h00, exl, ie};
  endfunction

  // Pack Cause.IP into the 32-bit read view.
  function automatic logic [31:0] pack_cause(input logic [5:0] ip);
    return {16'h0000, ip, 10'h000};
  endfunction

  // Architected state
  state_t      state_r;
  state_t      next_state_s;
  logic [5:0]  im_r;
  logic        ie_r;
  logic        exl_r;
  logic [5:0]  ip_r;
  logic [31:0] epc_r;
  logic        interupt_r;
  logic        int_end_r;
  logic        flush_r;

  // Combinational helpers
  logic        req_s;
  logic        take_s;
  logic        leave_return_s;
  logic        sr_wr_s;
  logic        epc_wr_s;
  logic [5:0]  im_next_s;
  logic        ie_next_s;
  logic        exl_next_s;
  logic [31:0] epc_next_s;
  logic [31:0] rd_data_s;

  assign req_s    = request_active(ip_r, im_r, ie_r, exl_r);
  assign sr_wr_s  = mtc0_we & (mtc0_addr == ADDR_SR);
  assign epc_wr_s = mtc0_we & (mtc0_addr == ADDR_EPC);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic and transition strobes
  always_comb begin
    next_state_s   = state_r;
    take_s         = 1'b0;
    leave_return_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A request with a bubble at commit stays pending until a real
        // instruction arrives, so EPC always names a real instruction.
        if (req_s && pc_valid) begin
          next_state_s = TAKE;
          take_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      TAKE: begin
        next_state_s = SERVICE;
      end
      SERVICE: begin
        if (eret) begin
          next_state_s = RETURN;
        end else begin
          next_state_s = SERVICE;
        end
      end
      RETURN: begin
        next_state_s   = IDLE;
        leave_return_s = 1'b1;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // SR next value: software writes first, then the FSM's EXL control wins
  always_comb begin
    im_next_s  = im_r;
    ie_next_s  = ie_r;
    exl_next_s = exl_r;
    if (sr_wr_s) begin
      im_next_s  = mtc0_data[15:10];
      ie_next_s  = mtc0_data[0];
      exl_next_s = mtc0_data[1];
    end else begin
      im_next_s  = im_r;
      ie_next_s  = ie_r;
      exl_next_s = exl_r;
    end
    if (take_s) begin
      exl_next_s = 1'b1;
    end else if (leave_return_s) begin
      exl_next_s = 1'b0;
    end else begin
      exl_next_s = exl_next_s;
    end
  end

  // EPC next value: capture of the interrupted PC beats a software write
  always_comb begin
    epc_next_s = epc_r;
    if (take_s) begin
      epc_next_s = pc_in;
    end else if (epc_wr_s) begin
      epc_next_s = mtc0_data;
    end else begin
      epc_next_s = epc_r;
    end
  end

  // SR, Cause.IP and EPC registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_r  <= 6'h00;
      ie_r  <= 1'b0;
      exl_r <= 1'b0;
      ip_r  <= 6'h00;
      epc_r <= 32'h0000_0000;
    end else begin
      im_r  <= im_next_s;
      ie_r  <= ie_next_s;
      exl_r <= exl_next_s;
      ip_r  <= hw_int;
      epc_r <= epc_next_s;
    end
  end

  // Output strobes registered from the next state, so they equal a pure
  // decode of the current state without any combinational input path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interupt_r <= 1'b0;
      int_end_r  <= 1'b0;
      flush_r    <= 1'b0;
    end else begin
      interupt_r <= (next_state_s == TAKE);
      int_end_r  <= (next_state_s == RETURN);
      flush_r    <= (next_state_s == TAKE) || (next_state_s == RETURN);
    end
  end

  // CP0 read mux; unmapped numbers read as zero
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (mfc0_addr)
      ADDR_SR:    rd_data_s = pack_sr(im_r, exl_r, ie_r);
      ADDR_CAUSE: rd_data_s = pack_cause(ip_r);
      ADDR_EPC:   rd_data_s = epc_r;
      ADDR_PRID:  rd_data_s = PRID;
      default:    rd_data_s = 32'h0000_0000;
    endcase
  end

  assign mfc0_data = rd_data_s;
  assign epc_out   = epc_r;
  assign interupt  = interupt_r;
  assign int_end   = int_end_r;
  assign flush     = flush_r;

endmodule
